// File: rtl/tiger_muldiv_unit.sv
// Iterative multiply/divide unit that owns HI/LO and requests Ex stalls while busy.
// Optional build macro TIGER_MULDIV_FAST_MUL_EN replaces the shift-add multiply with one registered multiply.
module tiger_muldiv_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] opA,
    input  logic [DATA_WIDTH-1:0] opB,
    input  logic                  hold,
    output logic                  stallRq,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int W = DATA_WIDTH;
    localparam logic [COUNT_WIDTH-1:0] LAST = COUNT_WIDTH'(DATA_WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MFHI  = 3'd6;
    localparam logic [2:0] OP_MFLO  = 3'd7;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t                 state;
    logic [COUNT_WIDTH-1:0] count;
    logic [2*W-1:0]         acc;
    logic [W-1:0]           a_mag;
    logic [W-1:0]           b_mag;
    logic                   is_div;
    logic                   neg_q;
    logic                   neg_r;

    function automatic logic [W-1:0] magnitude(input logic [W-1:0] x, input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    logic accept, signed_op, is_mul_op, is_div_op, sign_a, sign_b;

    assign busy      = (state != IDLE);
    assign stallRq   = op_valid && busy;
    assign accept    = op_valid && !busy && !hold;
    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div_op = (op == OP_DIV)  || (op == OP_DIVU);
    assign sign_a    = signed_op && opA[W-1];
    assign sign_b    = signed_op && opB[W-1];

    always_comb begin
        result = '0;
        if (op == OP_MFHI) result = hi;
        else if (op == OP_MFLO) result = lo;
    end

    // Restoring divide step: acc = {remainder, dividend bits shifting into quotient}.
    // The subtraction's top bit is the borrow because the shifted remainder is below 2*divisor.
    logic [W:0]     div_shift, div_diff;
    logic [2*W-1:0] div_next;
    assign div_shift = {acc[2*W-1:W], acc[W-1]};
    assign div_diff  = div_shift - {1'b0, b_mag};
    assign div_next  = !div_diff[W] ? {div_diff[W-1:0], acc[W-2:0], 1'b1}
                                    : {div_shift[W-1:0], acc[W-2:0], 1'b0};

`ifndef TIGER_MULDIV_FAST_MUL_EN
    // Shift-add step: acc = {partial product, remaining multiplier bits}.
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    assign mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, a_mag};
    assign mul_next = acc[0] ? {mul_sum, acc[W-1:1]} : {1'b0, acc[2*W-1:1]};
`endif

    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   q_fix, r_fix;
    assign prod_fix = neg_q ? -acc : acc;
    assign q_fix    = neg_q ? -acc[W-1:0] : acc[W-1:0];
    assign r_fix    = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            hi     <= '0;
            lo     <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mul_op) begin
                            state  <= MUL;
                            is_div <= 1'b0;
                            neg_q  <= sign_a ^ sign_b;
                            neg_r  <= 1'b0;
                        end else if (is_div_op) begin
                            is_div <= 1'b1;
                            if (opB == '0) begin
                                state <= FIX;
                                neg_q <= 1'b0;
                                neg_r <= 1'b0;
                            end else begin
                                state <= DIV;
                                neg_q <= sign_a ^ sign_b;
                                neg_r <= sign_a;
                            end
                        end else if (op == OP_MTHI) begin
                            hi <= opA;
                        end else if (op == OP_MTLO) begin
                            lo <= opA;
                        end
                    end
                end
                MUL: begin
`ifdef TIGER_MULDIV_FAST_MUL_EN
                    state <= FIX;
`else
                    if (count == LAST) begin
                        count <= '0;
                        state <= FIX;
                    end else begin
                        count <= count + 1'b1;
                    end
`endif
                end
                DIV: begin
                    if (count == LAST) begin
                        count <= '0;
                        state <= FIX;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    if (is_div) begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end else begin
                        hi <= prod_fix[2*W-1:W];
                        lo <= prod_fix[W-1:0];
                    end
                end
            endcase
        end
    end

    // Datapath registers carry no reset; an aborted op leaves them unobservable.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            if (accept && (is_mul_op || is_div_op)) begin
                a_mag <= magnitude(opA, sign_a);
                b_mag <= magnitude(opB, sign_b);
                if (is_div_op && opB == '0) acc <= {opA, {W{1'b1}}};
                else if (is_div_op)         acc <= {{W{1'b0}}, magnitude(opA, sign_a)};
                else                        acc <= {{W{1'b0}}, magnitude(opB, sign_b)};
            end
        end else if (state == MUL) begin
`ifdef TIGER_MULDIV_FAST_MUL_EN
            acc <= {{W{1'b0}}, a_mag} * {{W{1'b0}}, b_mag};
`else
            acc <= mul_next;
`endif
        end else if (state == DIV) begin
            acc <= div_next;
        end
    end
endmodule

// File: tb/tb_tiger_muldiv_unit.sv
// Randomized and directed bench for tiger_muldiv_unit against an arithmetic HI/LO model.
module tb_tiger_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] opA, opB;
    logic        hold;
    logic        stallRq, busy;
    logic [31:0] hi, lo, result;

    int n_checks = 0;
    int n_errors = 0;

    int          m_left = 0;
    logic [31:0] m_hi = 32'h0, m_lo = 32'h0, p_hi = 32'h0, p_lo = 32'h0;

`ifdef TIGER_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif

    tiger_muldiv_unit dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .opA(opA), .opB(opB),
        .hold(hold), .stallRq(stallRq), .busy(busy), .hi(hi), .lo(lo), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural effect of one clock edge: pending result lands after its latency.
    task automatic model_edge(input logic acc, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint q, r;
        logic [63:0] pu;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (acc) begin
            case (o)
                3'd0: begin
                    q = longint'($signed(a)) * longint'($signed(b));
                    p_hi = q[63:32]; p_lo = q[31:0]; m_left = MUL_LAT;
                end
                3'd1: begin
                    pu = {32'h0, a} * {32'h0, b};
                    p_hi = pu[63:32]; p_lo = pu[31:0]; m_left = MUL_LAT;
                end
                3'd2, 3'd3: begin
                    if (b == 32'h0) begin
                        p_hi = a; p_lo = 32'hFFFFFFFF; m_left = 1;
                    end else if (o == 3'd2) begin
                        q = longint'($signed(a)) / longint'($signed(b));
                        r = longint'($signed(a)) % longint'($signed(b));
                        p_lo = q[31:0]; p_hi = r[31:0]; m_left = 33;
                    end else begin
                        p_lo = a / b; p_hi = a % b; m_left = 33;
                    end
                end
                3'd4: m_hi = a;
                3'd5: m_lo = a;
                default: ;
            endcase
        end
    endtask

    task automatic cycle(input logic v, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic h);
        logic acc;
        op_valid = v; op = o; opA = a; opB = b; hold = h;
        @(negedge clk);
        check_val("busy", 32'(busy), 32'(m_left != 0));
        check_val("stallRq", 32'(stallRq), 32'(v && m_left != 0));
        check_val("hi", hi, m_hi);
        check_val("lo", lo, m_lo);
        if (v && m_left == 0)
            check_val("result", result, (o == 3'd6) ? m_hi : ((o == 3'd7) ? m_lo : 32'h0));
        acc = v && (m_left == 0) && !h;
        @(posedge clk);
        #1;
        model_edge(acc, o, a, b);
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        cycle(1'b1, o, a, b, 1'b0);
        for (int i = 0; i < 40 && m_left != 0; i++) cycle(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        check_val({tag, "_hi"}, hi, exp_hi);
        check_val({tag, "_lo"}, lo, exp_lo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; op_valid = 1'b1; op = 3'd7; opA = 32'h0; opB = 32'h0; hold = 1'b0;
        #3;
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_stall", 32'(stallRq), 32'h0);
        check_val("rst_hi", hi, 32'h0);
        check_val("rst_lo", lo, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_neg", 3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("divu_zero", 3'd3, 32'd5, 32'h0, 32'd5, 32'hFFFFFFFF);
        run_op("div_minneg", 3'd2, 32'h80000000, 32'd3, 32'hFFFFFFFE, 32'hD5555556);
        run_op("multu_small", 3'd1, 32'd3, 32'd5, 32'd0, 32'd15);

        // DIVU then MFLO stalled behind it until the unit frees up.
        cycle(1'b1, 3'd3, 32'd100, 32'd7, 1'b0);
        for (int i = 0; i < 40 && m_left != 0; i++) cycle(1'b1, 3'd7, 32'h0, 32'h0, 1'b0);
        check_val("mflo_stall", 32'(stallRq), 32'h0);
        check_val("mflo_result", result, 32'd14);

        // MTHI held off for three cycles.
        for (int i = 0; i < 3; i++) cycle(1'b1, 3'd4, 32'hCAFEF00D, 32'h0, 1'b1);
        check_val("mthi_held", hi, 32'd2);
        cycle(1'b1, 3'd4, 32'hCAFEF00D, 32'h0, 1'b0);
        check_val("mthi_write", hi, 32'hCAFEF00D);

        // Asynchronous reset in the middle of a divide.
        cycle(1'b1, 3'd2, 32'd1000, 32'hFFFFFFFD, 1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        op_valid = 1'b1; op = 3'd7;
        #1 reset = 1'b1;
        #1;
        check_val("arst_busy", 32'(busy), 32'h0);
        check_val("arst_stall", 32'(stallRq), 32'h0);
        check_val("arst_hi", hi, 32'h0);
        check_val("arst_lo", lo, 32'h0);
        #1 reset = 1'b0;
        m_left = 0; m_hi = 32'h0; m_lo = 32'h0;

        for (int i = 0; i < 1500; i++)
            cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), pick(), pick(), $urandom_range(0, 4) == 0);
        for (int i = 0; i < 40 && m_left != 0; i++) cycle(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
